// File: rtl/blur_pkg.sv
// Shared types and kernel helpers for the parametrised 3x3 blur engine.
//   blur_mode_e  : run-time kernel select
//   blur_state_e : sequencer states
//   tap_weight() : weight of tap k (raster over dy,dx = -1..1) for a mode
//   tap_shift()  : normalising right shift for a mode
package blur_pkg;

  localparam int KERNEL_TAPS = 9;

  typedef enum logic [1:0] {
    BLUR_GAUSS = 2'd0,
    BLUR_IDENT = 2'd1,
    BLUR_HORIZ = 2'd2,
    BLUR_VERT  = 2'd3
  } blur_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } blur_state_e;

  // Weight = rowW(dy) * colW(dx); a blurred axis uses 1,2,1, a pass-through axis 0,1,0.
  function automatic logic [2:0] tap_weight(blur_mode_e mode, logic [3:0] k);
    logic [1:0] ri, ci, rw, cw;
    ri = (k < 4'd3) ? 2'd0 : (k < 4'd6) ? 2'd1 : 2'd2;
    ci = (k == 4'd0 || k == 4'd3 || k == 4'd6) ? 2'd0 :
         (k == 4'd1 || k == 4'd4 || k == 4'd7) ? 2'd1 : 2'd2;
    if (mode == BLUR_GAUSS || mode == BLUR_VERT) rw = (ri == 2'd1) ? 2'd2 : 2'd1;
    else                                         rw = (ri == 2'd1) ? 2'd1 : 2'd0;
    if (mode == BLUR_GAUSS || mode == BLUR_HORIZ) cw = (ci == 2'd1) ? 2'd2 : 2'd1;
    else                                          cw = (ci == 2'd1) ? 2'd1 : 2'd0;
    return 3'(rw) * 3'(cw);
  endfunction

  function automatic logic [2:0] tap_shift(blur_mode_e mode);
    case (mode)
      BLUR_GAUSS: return 3'd4;
      BLUR_IDENT: return 3'd0;
      default:    return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/blur_window_addr.sv
// Combinational clamped tap address for the 3x3 window.
//   x_i, y_i     : centre pixel coordinates
//   row_base_i   : y_i*WIDTH, maintained incrementally by the caller
//   tap_i        : tap index 0..8, raster over dy,dx = -1..1
//   addr_o       : address of the tap with edge-replicate clamping
module blur_window_addr #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64
) (
  input  logic [$clog2(WIDTH)-1:0]        x_i,
  input  logic [$clog2(HEIGHT)-1:0]       y_i,
  input  logic [$clog2(WIDTH*HEIGHT)-1:0] row_base_i,
  input  logic [3:0]                      tap_i,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] addr_o
);
  localparam int AW = $clog2(WIDTH*HEIGHT);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic          dy_neg, dy_pos, dx_neg, dx_pos;
  logic [AW-1:0] row_addr;
  logic [XW-1:0] col;

  always_comb begin
    dy_neg = (tap_i < 4'd3);
    dy_pos = (tap_i > 4'd5);
    dx_neg = (tap_i == 4'd0 || tap_i == 4'd3 || tap_i == 4'd6);
    dx_pos = (tap_i == 4'd2 || tap_i == 4'd5 || tap_i == 4'd8);

    row_addr = row_base_i;
    if (dy_neg && y_i != '0)                    row_addr = row_base_i - AW'(WIDTH);
    else if (dy_pos && y_i != YW'(HEIGHT - 1))  row_addr = row_base_i + AW'(WIDTH);

    col = x_i;
    if (dx_neg && x_i != '0)                    col = x_i - XW'(1);
    else if (dx_pos && x_i != XW'(WIDTH - 1))   col = x_i + XW'(1);

    addr_o = row_addr + AW'(col);
  end

endmodule

// File: rtl/blur_img_param.sv
// Parametrised 3x3 separable blur: reads a frame from a BRAM with fixed
// registered read latency, applies the selected kernel with clamped borders
// and streams one result per pixel to a write port.
//   clk_in, rst_n_in            : clock, async active-low reset
//   start_in, mode_in           : start request, kernel select (latched on start)
//   ext_read_addr[_valid]       : source BRAM address / enable
//   ext_pixel_in                : source data, READ_LATENCY cycles after address
//   ext_write_addr/_valid       : destination address (y*WIDTH+x) / strobe
//   ext_pixel_out               : blurred pixel
//   busy_out, blur_done         : frame in progress, completion pulse
//
// state    | meaning
// ST_IDLE  | waiting for start_in
// ST_FETCH | issue the 9 tap reads, k = 0..8
// ST_DRAIN | wait READ_LATENCY cycles for the last taps to land
// ST_WRITE | emit the pixel, advance x/y
// ST_DONE  | one-cycle completion pulse
module blur_img_param
  import blur_pkg::*;
#(
  parameter int BIT_DEPTH    = 8,
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            start_in,
  input  logic [1:0]                      mode_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] ext_read_addr,
  output logic                            ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]            ext_pixel_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] ext_write_addr,
  output logic                            ext_write_valid,
  output logic [BIT_DEPTH-1:0]            ext_pixel_out,
  output logic                            busy_out,
  output logic                            blur_done
);
  localparam int AW   = $clog2(WIDTH*HEIGHT);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int ACCW = BIT_DEPTH + 4;
  localparam int DW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  blur_state_e   state_q, state_d;
  blur_mode_e    mode_q, mode_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [3:0]    k_q, k_d;
  logic [DW-1:0] drn_q, drn_d;
  logic [ACCW-1:0] acc_q, acc_d;

  // Tap-valid and weight travel alongside the BRAM read pipeline.
  logic [READ_LATENCY-1:0] vld_q;
  logic [2:0]              w_q [READ_LATENCY];

  logic [AW-1:0]        tap_addr;
  logic [2:0]           shift;
  logic [ACCW-1:0]      rnd;
  logic [BIT_DEPTH-1:0] res;

  blur_window_addr #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_window_addr (
    .x_i        (x_q),
    .y_i        (y_q),
    .row_base_i (row_base_q),
    .tap_i      (k_q),
    .addr_o     (tap_addr)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    k_d        = k_q;
    drn_d      = drn_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d    = ST_FETCH;
          mode_d     = blur_mode_e'(mode_in);
          x_d        = '0;
          y_d        = '0;
          row_base_d = '0;
          k_d        = '0;
        end
      end
      ST_FETCH: begin
        if (k_q == 4'(KERNEL_TAPS - 1)) begin
          state_d = ST_DRAIN;
          k_d     = '0;
          drn_d   = DW'(READ_LATENCY - 1);
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (drn_q == '0) state_d = ST_WRITE;
        else             drn_d   = drn_q - DW'(1);
      end
      ST_WRITE: begin
        state_d = ST_FETCH;
        if (x_q == XW'(WIDTH - 1)) begin
          x_d = '0;
          if (y_q == YW'(HEIGHT - 1)) begin
            state_d = ST_DONE;
          end else begin
            y_d        = y_q + YW'(1);
            row_base_d = row_base_q + AW'(WIDTH);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (state_q == ST_FETCH && k_q == '0) acc_d = '0;
    if (vld_q[READ_LATENCY-1])
      acc_d = acc_d + ACCW'(ext_pixel_in) * ACCW'(w_q[READ_LATENCY-1]);
  end

  // Round half up before the normalising shift.
  always_comb begin
    shift = tap_shift(mode_q);
    rnd   = (shift == 3'd0) ? '0 : (ACCW'(1) << (shift - 3'd1));
    res   = BIT_DEPTH'((acc_q + rnd) >> shift);
  end

  always_comb begin
    ext_read_addr_valid = (state_q == ST_FETCH);
    ext_read_addr       = (state_q == ST_FETCH) ? tap_addr : '0;
    ext_write_valid     = (state_q == ST_WRITE);
    ext_write_addr      = (state_q == ST_WRITE) ? (row_base_q + AW'(x_q)) : '0;
    ext_pixel_out       = (state_q == ST_WRITE) ? res : '0;
    busy_out            = (state_q == ST_FETCH) || (state_q == ST_DRAIN) || (state_q == ST_WRITE);
    blur_done           = (state_q == ST_DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      mode_q     <= BLUR_GAUSS;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      k_q        <= '0;
      drn_q      <= '0;
      acc_q      <= '0;
      vld_q      <= '0;
      for (int i = 0; i < READ_LATENCY; i++) w_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      k_q        <= k_d;
      drn_q      <= drn_d;
      acc_q      <= acc_d;
      vld_q[0]   <= (state_q == ST_FETCH);
      w_q[0]     <= tap_weight(mode_q, k_q);
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        w_q[i]   <= w_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_blur_img_param.sv
module tb_blur_img_param;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int RL  = 2;
  localparam int BD  = 8;
  localparam int N   = W * H;
  localparam int AW  = $clog2(N);
  localparam int LAT = N * (10 + RL);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_vld, wr_vld, busy, done;
  logic [BD-1:0] pix_in, pix_out;

  always #5 clk = ~clk;

  blur_img_param #(
    .BIT_DEPTH    (BD),
    .WIDTH        (W),
    .HEIGHT       (H),
    .READ_LATENCY (RL)
  ) dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n),
    .start_in            (start),
    .mode_in             (mode),
    .ext_read_addr       (rd_addr),
    .ext_read_addr_valid (rd_vld),
    .ext_pixel_in        (pix_in),
    .ext_write_addr      (wr_addr),
    .ext_write_valid     (wr_vld),
    .ext_pixel_out       (pix_out),
    .busy_out            (busy),
    .blur_done           (done)
  );

  // Source frame and a two-stage registered BRAM read; idle slots carry noise.
  logic [BD-1:0] img [N];
  logic [BD-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= rd_vld ? img[rd_addr] : BD'($urandom);
    p2 <= p1;
  end
  assign pix_in = p2;

  typedef struct {int addr; int data;} exp_t;
  exp_t sb[$];
  exp_t e;
  int   out_img [N];
  int   hz [W] = '{4, 16, 32, 44};
  int   n_total, n_pass, cyc, fetch_cyc, wr_cnt, done_cnt, frame_w0, frame_d0, w0, d0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: direct 3x3 weighted sum over clamped coordinates.
  function automatic int ref_pix(int m, int x, int y);
    int sum = 0;
    int sh, rw, cw, xx, yy;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        rw = (m == 0 || m == 3) ? ((dy == 0) ? 2 : 1) : ((dy == 0) ? 1 : 0);
        cw = (m == 0 || m == 2) ? ((dx == 0) ? 2 : 1) : ((dx == 0) ? 1 : 0);
        yy = (y + dy < 0) ? 0 : (y + dy > H - 1) ? H - 1 : y + dy;
        xx = (x + dx < 0) ? 0 : (x + dx > W - 1) ? W - 1 : x + dx;
        sum += rw * cw * int'(img[yy*W + xx]);
      end
    end
    sh = (m == 0) ? 4 : (m == 1) ? 0 : 2;
    return (sum + ((1 << sh) / 2)) >> sh;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_vld) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("write_with_empty_scoreboard", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("wr_addr", int'(wr_addr), e.addr);
        check("wr_data", int'(pix_out), e.data);
        out_img[wr_addr] = int'(pix_out);
      end
    end
  end

  task automatic check_outputs_zero(string tag);
    check({tag, "_rd_vld"},  int'(rd_vld), 0);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
    check({tag, "_wr_vld"},  int'(wr_vld), 0);
    check({tag, "_wr_addr"}, int'(wr_addr), 0);
    check({tag, "_pix_out"}, int'(pix_out), 0);
    check({tag, "_busy"},    int'(busy), 0);
    check({tag, "_done"},    int'(done), 0);
  endtask

  task automatic launch(int m);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        sb.push_back('{y*W + x, ref_pix(m, x, y)});
    frame_w0 = wr_cnt;
    frame_d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 2'(m);
    @(posedge clk); #1;
    fetch_cyc = cyc;
    start = 1'b0;
    mode  = 2'($urandom);
  endtask

  task automatic wait_frame(string tag);
    int busy_bad = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!busy) busy_bad++;
      if (cyc - fetch_cyc > LAT + 50) break;
    end
    check({tag, "_done_latency"}, cyc - fetch_cyc, LAT);
    check({tag, "_busy_in_frame"}, busy_bad, 0);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    @(negedge clk);
    check({tag, "_done_width"}, int'(done), 0);
    check({tag, "_done_count"}, done_cnt - frame_d0, 1);
    check({tag, "_write_count"}, wr_cnt - frame_w0, N);
    check({tag, "_sb_empty"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic rand_img();
    for (int i = 0; i < N; i++) img[i] = BD'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) img[i] = 8'd255;
    launch(0);
    wait_frame("const255");

    for (int i = 0; i < N; i++) img[i] = 8'd0;
    img[1*W + 1] = 8'd160;
    launch(0);
    wait_frame("impulse");
    check("impulse_1_1", out_img[1*W + 1], 40);
    check("impulse_0_1", out_img[1*W + 0], 20);
    check("impulse_1_0", out_img[0*W + 1], 20);
    check("impulse_0_0", out_img[0], 10);
    check("impulse_2_2", out_img[2*W + 2], 10);
    check("impulse_3_3", out_img[3*W + 3], 0);

    for (int i = 0; i < N; i++) img[i] = BD'(16 * (i % W));
    launch(2);
    wait_frame("rows_h");
    for (int i = 0; i < N; i++) check("rows_h_val", out_img[i], hz[i % W]);
    launch(1);
    wait_frame("rows_i");
    for (int i = 0; i < N; i++) check("rows_i_val", out_img[i], int'(img[i]));
    launch(3);
    wait_frame("rows_v");
    for (int i = 0; i < N; i++) check("rows_v_val", out_img[i], int'(img[i]));

    rand_img();
    launch(0);
    repeat (48) @(posedge clk);
    #1;
    start = 1'b1;
    mode  = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_frame("restart_ignored");

    rand_img();
    launch(0);
    repeat (99) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("midreset_no_writes", wr_cnt - w0, 0);
    check("midreset_no_done", done_cnt - d0, 0);
    check("midreset_idle", int'(busy), 0);

    for (int f = 0; f < 4; f++) begin
      rand_img();
      launch(int'($urandom_range(0, 3)));
      wait_frame("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/blur_img_param.md
Name: blur_img_param

Overview:
- Parametrised successor to the fixed 3x3 Gaussian image blur engine.
- Reads a WIDTH x HEIGHT greyscale frame from an external single-port BRAM with a fixed registered read latency.
- Applies one of four run-time selectable separable 3x3 kernels with edge-replicate (clamp) borders.
- Streams results to an external write port; sits between the frame-store BRAM and the next SIFT pyramid stage.

Parameters:
- BIT_DEPTH, 8, pixel width in bits.
- WIDTH, 64, frame width in pixels (>=2).
- HEIGHT, 64, frame height in pixels (>=2).
- READ_LATENCY, 2, cycles from ext_read_addr_valid to ext_pixel_in valid (2 = HIGH_PERFORMANCE BRAM).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle start request.
- mode_in  input  2  kernel select, latched on accepted start.
- ext_read_addr  output  $clog2(WIDTH*HEIGHT)  source BRAM address.
- ext_read_addr_valid  output  1  source BRAM enable.
- ext_pixel_in  input  BIT_DEPTH  source BRAM data.
- ext_write_addr  output  $clog2(WIDTH*HEIGHT)  destination address, y*WIDTH+x.
- ext_write_valid  output  1  destination write strobe.
- ext_pixel_out  output  BIT_DEPTH  blurred pixel.
- busy_out  output  1  high from accepted start until done.
- blur_done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0; x=y=0; accumulator 0. Asserting reset mid-frame aborts immediately, emits no done pulse and issues no further writes.
- Modes:
  - 0 = full Gaussian [1 2 1]x[1 2 1], shift 4.
  - 1 = identity (centre tap only), shift 0.
  - 2 = horizontal [1 2 1], shift 2.
  - 3 = vertical [1 2 1], shift 2.
  - Tap weight = rowW(dy) * colW(dx). Gaussian axis: 1,2,1. Non-Gaussian axis: 0,1,0.
- Accumulator width BIT_DEPTH+4, unsigned.
- Result = (acc + (shift ? 1<<(shift-1) : 0)) >> shift (round-half-up). It never exceeds 2^BIT_DEPTH-1, so no saturation logic is needed.
- Tap order k=0..8 is raster over dy=-1..1, dx=-1..1. Coordinates are clamped to [0,WIDTH-1] and [0,HEIGHT-1].
- FSM: IDLE -> FETCH -> DRAIN -> WRITE -> (FETCH | DONE) -> IDLE.
  - IDLE: start_in=1 latches mode_in, sets busy_out=1, x=y=0, enters FETCH on the next edge.
  - FETCH: 9 cycles. ext_read_addr_valid=1, ext_read_addr = clamped tap k address. Clear acc at k=0.
  - Data for tap k is sampled from ext_pixel_in exactly READ_LATENCY cycles after its address cycle, multiplied by its weight, and accumulated.
  - DRAIN: READ_LATENCY cycles, ext_read_addr_valid=0.
  - WRITE: 1 cycle. ext_write_valid=1, ext_write_addr=y*WIDTH+x, ext_pixel_out=result. Advance x; wrap x to 0 at WIDTH-1 and increment y.
  - After pixel (WIDTH-1,HEIGHT-1) go to DONE. DONE: blur_done=1 for one cycle, busy_out=0, return to IDLE.
- Per-pixel period: 10+READ_LATENCY cycles. Frame time: WIDTH*HEIGHT*(10+READ_LATENCY) cycles, i.e. 49152 at defaults.
- start_in while busy is ignored, and mode is not re-latched. start_in in the DONE cycle is ignored.
- ext_write_valid, ext_pixel_out and ext_write_addr are 0 outside WRITE. ext_read_addr is 0 outside FETCH.
- Pixel addresses use incrementally maintained row-base registers (no multiplier).

Decomposition:
- Package blur_pkg:
  - mode enum: BLUR_GAUSS, BLUR_IDENT, BLUR_HORIZ, BLUR_VERT.
  - state enum.
  - KERNEL_TAPS=9.
  - functions tap_weight(mode,k) and tap_shift(mode).
- Sub-module blur_window_addr: given x, y, row base and tap index, returns the clamped tap address combinationally.

Test Plan (WIDTH=HEIGHT=4, READ_LATENCY=2 unless stated):
- Constant 255 frame, mode 0 -> all 16 outputs 255; blur_done exactly 192 cycles after the first FETCH cycle; busy_out high throughout.
- Impulse: (1,1)=160, all others 0, mode 0:
  - out(1,1)=40, out(0,1)=20, out(1,0)=20, out(0,0)=10, out(2,2)=10, out(3,3)=0.
- Rows [0,16,32,48], mode 2 -> each row [4,16,32,44] (clamp + rounding); mode 1 -> output equals input; mode 3 -> output equals input.
- start_in pulsed again at cycle 50 with mode_in=1 during a mode-0 run -> ignored; results match the mode-0 golden; exactly one blur_done.
- rst_n_in low for 1 cycle at cycle 100 -> all outputs 0 next cycle; no writes or done afterwards; a new start completes a full correct frame.
- Default 64x64, image.mem, mode 0 -> 4096 writes, each address written once in raster order; outputs match the Python golden model bit-exactly.
